// File: rtl/riscv_pc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_constants (package)
// Description : Shared encodings for the kana-riscv program-counter unit:
//               next-PC source select, PC unit state and redirect class.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_constants;

    localparam int PC_SEL_W = 3;

    // Next-PC source select. PC_MRET is appended after the original encodings.
    typedef enum logic [PC_SEL_W-1:0] {
        PC_PLUS4        = 3'd0,
        PC_ALU          = 3'd1,
        PC_B_TARGET     = 3'd2,
        PC_ECALL_TARGET = 3'd3,
        PC_MRET         = 3'd4
    } pc_sel_t;

    // PC unit state: BOOT for one cycle after reset, HELD while a redirect
    // is buffered during a stall, RUN otherwise.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HELD = 2'd2
    } pc_state_t;

    // Trap-class redirects take priority over jump-class redirects.
    typedef enum logic {
        RC_JUMP = 1'b0,
        RC_TRAP = 1'b1
    } redirect_class_t;

endpackage
`default_nettype wire

// File: rtl/riscv_pc_target.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pc_target
// Description : Combinational next-PC target selection with instruction
//               address misalignment check. A misaligned jump/branch target
//               is replaced by the trap vector and reported as trap class.
// Ports       : i_pc            current PC
//               i_pc_sel        next-PC source select
//               i_alu_out       JAL/JALR target
//               i_imm_b_sext    sign-extended branch offset
//               i_br_flag       branch taken
//               i_mtvec_addr    trap vector base
//               i_mepc          MRET return address
//               o_target        address to load (trap vector if misaligned)
//               o_check_addr    unmodified jump/branch target
//               o_is_redirect   selection is non-sequential
//               o_is_trap_class selection is ECALL, MRET or misalign trap
//               o_misaligned    jump/branch target violates IALIGN
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_pc_target
    import riscv_constants::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int PC_OFFSET   = 4,
    parameter int IALIGN      = 4
) (
    input  logic [WORD_LENGTH-1:0] i_pc,
    input  logic [PC_SEL_W-1:0]    i_pc_sel,
    input  logic [WORD_LENGTH-1:0] i_alu_out,
    input  logic [WORD_LENGTH-1:0] i_imm_b_sext,
    input  logic                   i_br_flag,
    input  logic [WORD_LENGTH-1:0] i_mtvec_addr,
    input  logic [WORD_LENGTH-1:0] i_mepc,
    output logic [WORD_LENGTH-1:0] o_target,
    output logic [WORD_LENGTH-1:0] o_check_addr,
    output logic                   o_is_redirect,
    output logic                   o_is_trap_class,
    output logic                   o_misaligned
);

    localparam logic [WORD_LENGTH-1:0] c_align_mask = WORD_LENGTH'(IALIGN - 1);
    localparam logic [WORD_LENGTH-1:0] c_offset     = WORD_LENGTH'(PC_OFFSET);

    logic [WORD_LENGTH-1:0] w_seq;
    logic [WORD_LENGTH-1:0] w_trap_vec;
    logic [WORD_LENGTH-1:0] w_cand;
    logic                   w_checked;
    logic                   w_redirect;
    logic                   w_trap;

    assign w_seq      = i_pc + c_offset;
    assign w_trap_vec = {i_mtvec_addr[WORD_LENGTH-1:2], 2'b00};

    always_comb begin
        w_cand     = w_seq;
        w_checked  = 1'b0;
        w_redirect = 1'b0;
        w_trap     = 1'b0;
        case (i_pc_sel)
            PC_ALU: begin
                w_cand     = {i_alu_out[WORD_LENGTH-1:1], 1'b0};
                w_checked  = 1'b1;
                w_redirect = 1'b1;
            end
            PC_B_TARGET: begin
                if (i_br_flag) begin
                    w_cand     = i_pc + i_imm_b_sext;
                    w_checked  = 1'b1;
                    w_redirect = 1'b1;
                end
            end
            PC_ECALL_TARGET: begin
                w_cand     = w_trap_vec;
                w_redirect = 1'b1;
                w_trap     = 1'b1;
            end
            PC_MRET: begin
                w_cand     = i_mepc;
                w_redirect = 1'b1;
                w_trap     = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_misaligned    = w_checked && ((w_cand & c_align_mask) != '0);
    assign o_target        = o_misaligned ? w_trap_vec : w_cand;
    assign o_check_addr    = w_cand;
    assign o_is_redirect   = w_redirect;
    assign o_is_trap_class = w_trap | o_misaligned;

endmodule
`default_nettype wire

// File: rtl/riscv_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pc_unit
// Description : Program-counter unit at the head of the fetch path. Supports
//               stalls with a one-entry redirect buffer, MRET return,
//               misalignment trapping and a configurable reset vector.
// Ports       : clk, x_reset (async active-low)
//               stall, pc_sel, alu_out, imm_b_sext, br_flag, mtvec_addr, mepc
//               pc_out, pc_plus4, pc_valid, redirect, misalign_exc,
//               misalign_addr, redirect_pending
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_pc_unit
    import riscv_constants::*;
#(
    parameter int                   WORD_LENGTH  = 32,
    parameter int                   PC_OFFSET    = 4,
    parameter int                   IALIGN       = 4,
    parameter logic [WORD_LENGTH-1:0] RESET_VECTOR = '0
) (
    input  logic                   clk,
    input  logic                   x_reset,
    input  logic                   stall,
    input  logic [PC_SEL_W-1:0]    pc_sel,
    input  logic [WORD_LENGTH-1:0] alu_out,
    input  logic [WORD_LENGTH-1:0] imm_b_sext,
    input  logic                   br_flag,
    input  logic [WORD_LENGTH-1:0] mtvec_addr,
    input  logic [WORD_LENGTH-1:0] mepc,
    output logic [WORD_LENGTH-1:0] pc_out,
    output logic [WORD_LENGTH-1:0] pc_plus4,
    output logic                   pc_valid,
    output logic                   redirect,
    output logic                   misalign_exc,
    output logic [WORD_LENGTH-1:0] misalign_addr,
    output logic                   redirect_pending
);

    pc_state_t              r_state,         w_state_nxt;
    logic [WORD_LENGTH-1:0] r_pc,            w_pc_nxt;
    logic [WORD_LENGTH-1:0] r_pend_addr,     w_pend_addr_nxt;
    redirect_class_t        r_pend_class,    w_pend_class_nxt;
    logic                   r_redirect,      w_redirect_nxt;
    logic                   r_misalign_exc,  w_misalign_exc_nxt;
    logic [WORD_LENGTH-1:0] r_misalign_addr, w_misalign_addr_nxt;

    logic [WORD_LENGTH-1:0] w_target;
    logic [WORD_LENGTH-1:0] w_check_addr;
    logic                   w_is_redirect;
    logic                   w_is_trap;
    logic                   w_misaligned;
    redirect_class_t        w_cur_class;

    riscv_pc_target #(
        .WORD_LENGTH (WORD_LENGTH),
        .PC_OFFSET   (PC_OFFSET),
        .IALIGN      (IALIGN)
    ) u_target (
        .i_pc            (r_pc),
        .i_pc_sel        (pc_sel),
        .i_alu_out       (alu_out),
        .i_imm_b_sext    (imm_b_sext),
        .i_br_flag       (br_flag),
        .i_mtvec_addr    (mtvec_addr),
        .i_mepc          (mepc),
        .o_target        (w_target),
        .o_check_addr    (w_check_addr),
        .o_is_redirect   (w_is_redirect),
        .o_is_trap_class (w_is_trap),
        .o_misaligned    (w_misaligned)
    );

    assign w_cur_class = w_is_trap ? RC_TRAP : RC_JUMP;

    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            r_state         <= BOOT;
            r_pc            <= RESET_VECTOR;
            r_pend_addr     <= '0;
            r_pend_class    <= RC_JUMP;
            r_redirect      <= 1'b0;
            r_misalign_exc  <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_pc            <= w_pc_nxt;
            r_pend_addr     <= w_pend_addr_nxt;
            r_pend_class    <= w_pend_class_nxt;
            r_redirect      <= w_redirect_nxt;
            r_misalign_exc  <= w_misalign_exc_nxt;
            r_misalign_addr <= w_misalign_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_pc_nxt            = r_pc;
        w_pend_addr_nxt     = r_pend_addr;
        w_pend_class_nxt    = r_pend_class;
        w_redirect_nxt      = 1'b0;
        w_misalign_exc_nxt  = 1'b0;
        w_misalign_addr_nxt = r_misalign_addr;
        case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                if (!stall) begin
                    w_pc_nxt       = w_target;
                    w_redirect_nxt = w_is_redirect;
                    if (w_misaligned) begin
                        w_misalign_exc_nxt  = 1'b1;
                        w_misalign_addr_nxt = w_check_addr;
                    end
                end else if (w_is_redirect) begin
                    // Misalignment is reported when the bad target is seen,
                    // not when the buffered trap vector is finally loaded.
                    w_state_nxt      = HELD;
                    w_pend_addr_nxt  = w_target;
                    w_pend_class_nxt = w_cur_class;
                    if (w_misaligned) begin
                        w_misalign_exc_nxt  = 1'b1;
                        w_misalign_addr_nxt = w_check_addr;
                    end
                end
            end
            HELD: begin
                if (stall) begin
                    // A buffered trap is never displaced by a later jump.
                    if (w_is_redirect &&
                        !(r_pend_class == RC_TRAP && w_cur_class == RC_JUMP)) begin
                        w_pend_addr_nxt  = w_target;
                        w_pend_class_nxt = w_cur_class;
                        if (w_misaligned) begin
                            w_misalign_exc_nxt  = 1'b1;
                            w_misalign_addr_nxt = w_check_addr;
                        end
                    end
                end else begin
                    w_state_nxt    = RUN;
                    w_redirect_nxt = 1'b1;
                    if (w_cur_class == RC_TRAP && r_pend_class == RC_JUMP) begin
                        w_pc_nxt = w_target;
                        if (w_misaligned) begin
                            w_misalign_exc_nxt  = 1'b1;
                            w_misalign_addr_nxt = w_check_addr;
                        end
                    end else begin
                        w_pc_nxt = r_pend_addr;
                    end
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    assign pc_out           = r_pc;
    assign pc_plus4         = r_pc + WORD_LENGTH'(PC_OFFSET);
    assign pc_valid         = (r_state != BOOT);
    assign redirect         = r_redirect;
    assign misalign_exc     = r_misalign_exc;
    assign misalign_addr    = r_misalign_addr;
    assign redirect_pending = (r_state == HELD);

endmodule
`default_nettype wire

// File: tb/tb_riscv_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_pc_unit
// Description : Self-checking bench for riscv_pc_unit. Two instances share
//               stimulus: index 0 uses IALIGN=4, index 1 uses IALIGN=2, both
//               with RESET_VECTOR=0x100. A behavioural model tracks each and
//               is compared on every falling clock edge; directed literal
//               expectations pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_pc_unit;
    import riscv_constants::*;

    localparam logic [31:0] c_rv = 32'h100;

    logic        clk = 1'b0;
    logic        x_reset;
    logic        stall;
    logic [2:0]  pc_sel;
    logic [31:0] alu_out, imm_b_sext, mtvec_addr, mepc;
    logic        br_flag;

    logic [31:0] pc_out_d[2], pc_plus4_d[2], misalign_addr_d[2];
    logic        pc_valid_d[2], redirect_d[2], misalign_exc_d[2], pending_d[2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    riscv_pc_unit #(.WORD_LENGTH(32), .PC_OFFSET(4), .IALIGN(4), .RESET_VECTOR(c_rv)) dut4 (
        .clk(clk), .x_reset(x_reset), .stall(stall), .pc_sel(pc_sel),
        .alu_out(alu_out), .imm_b_sext(imm_b_sext), .br_flag(br_flag),
        .mtvec_addr(mtvec_addr), .mepc(mepc),
        .pc_out(pc_out_d[0]), .pc_plus4(pc_plus4_d[0]), .pc_valid(pc_valid_d[0]),
        .redirect(redirect_d[0]), .misalign_exc(misalign_exc_d[0]),
        .misalign_addr(misalign_addr_d[0]), .redirect_pending(pending_d[0])
    );

    riscv_pc_unit #(.WORD_LENGTH(32), .PC_OFFSET(4), .IALIGN(2), .RESET_VECTOR(c_rv)) dut2 (
        .clk(clk), .x_reset(x_reset), .stall(stall), .pc_sel(pc_sel),
        .alu_out(alu_out), .imm_b_sext(imm_b_sext), .br_flag(br_flag),
        .mtvec_addr(mtvec_addr), .mepc(mepc),
        .pc_out(pc_out_d[1]), .pc_plus4(pc_plus4_d[1]), .pc_valid(pc_valid_d[1]),
        .redirect(redirect_d[1]), .misalign_exc(misalign_exc_d[1]),
        .misalign_addr(misalign_addr_d[1]), .redirect_pending(pending_d[1])
    );

    // ------------------------------------------------------------------ model
    typedef struct packed {
        logic [31:0] pc;
        logic        boot;
        logic        pv;      // pending entry present
        logic [31:0] pa;      // pending address
        logic        pt;      // pending entry is trap class
        logic        rd;      // redirect
        logic        me;      // misalign_exc
        logic [31:0] ma;      // misalign_addr
    } mstate_t;

    mstate_t m[2];

    function automatic mstate_t mreset();
        mstate_t s;
        s = '0;
        s.pc   = c_rv;
        s.boot = 1'b1;
        return s;
    endfunction

    function automatic mstate_t mnext(mstate_t s, int ialign);
        mstate_t     n;
        logic [31:0] t, raw, tvec;
        logic        nonseq, trap, bad;
        n    = s;
        n.rd = 1'b0;
        n.me = 1'b0;
        if (s.boot) begin
            n.boot = 1'b0;
            return n;
        end
        tvec   = mtvec_addr & ~32'h3;
        raw    = s.pc + 32'd4;
        nonseq = 1'b0;
        trap   = 1'b0;
        bad    = 1'b0;
        if (pc_sel == PC_ALU) begin
            raw = alu_out & ~32'h1;
            nonseq = 1'b1;
            bad = (raw % ialign) != 0;
        end else if (pc_sel == PC_B_TARGET && br_flag) begin
            raw = s.pc + imm_b_sext;
            nonseq = 1'b1;
            bad = (raw % ialign) != 0;
        end else if (pc_sel == PC_ECALL_TARGET) begin
            raw = tvec; nonseq = 1'b1; trap = 1'b1;
        end else if (pc_sel == PC_MRET) begin
            raw = mepc; nonseq = 1'b1; trap = 1'b1;
        end
        t = bad ? tvec : raw;
        if (bad) trap = 1'b1;

        if (stall) begin
            if (nonseq && !(s.pv && s.pt && !trap)) begin
                n.pv = 1'b1; n.pa = t; n.pt = trap;
                if (bad) begin n.me = 1'b1; n.ma = raw; end
            end
        end else if (s.pv) begin
            n.pv = 1'b0;
            n.rd = 1'b1;
            if (trap && !s.pt) begin
                n.pc = t;
                if (bad) begin n.me = 1'b1; n.ma = raw; end
            end else begin
                n.pc = s.pa;
            end
        end else begin
            n.pc = t;
            n.rd = nonseq;
            if (bad) begin n.me = 1'b1; n.ma = raw; end
        end
        return n;
    endfunction

    always @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            m[0] <= mreset();
            m[1] <= mreset();
        end else begin
            m[0] <= mnext(m[0], 4);
            m[1] <= mnext(m[1], 2);
        end
    end

    // ---------------------------------------------------------------- checks
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model d%0d pc_out", k),        pc_out_d[k],           m[k].pc);
            chk($sformatf("model d%0d pc_plus4", k),      pc_plus4_d[k],         m[k].pc + 32'd4);
            chk($sformatf("model d%0d pc_valid", k),      32'(pc_valid_d[k]),    32'(!m[k].boot));
            chk($sformatf("model d%0d redirect", k),      32'(redirect_d[k]),    32'(m[k].rd));
            chk($sformatf("model d%0d misalign_exc", k),  32'(misalign_exc_d[k]),32'(m[k].me));
            chk($sformatf("model d%0d misalign_addr", k), misalign_addr_d[k],    m[k].ma);
            chk($sformatf("model d%0d pending", k),       32'(pending_d[k]),     32'(m[k].pv));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic both(input string name, input logic [31:0] a0, input logic [31:0] e0,
                        input logic [31:0] a1, input logic [31:0] e1);
        chk({"d4 ", name}, a0, e0);
        chk({"d2 ", name}, a1, e1);
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        x_reset = 1'b0; stall = 1'b0; pc_sel = PC_PLUS4;
        alu_out = '0; imm_b_sext = '0; br_flag = 1'b0;
        mtvec_addr = 32'h80; mepc = '0;
        repeat (2) cyc();
        both("reset pc_out", pc_out_d[0], 32'h100, pc_out_d[1], 32'h100);
        both("reset pending", 32'(pending_d[0]), 0, 32'(pending_d[1]), 0);

        // Reset release and sequential boot
        x_reset = 1'b1;
        both("boot pc_valid", 32'(pc_valid_d[0]), 0, 32'(pc_valid_d[1]), 0);
        cyc();
        both("run pc_valid", 32'(pc_valid_d[0]), 1, 32'(pc_valid_d[1]), 1);
        both("first pc", pc_out_d[0], 32'h100, pc_out_d[1], 32'h100);
        cyc();
        both("seq pc 104", pc_out_d[0], 32'h104, pc_out_d[1], 32'h104);
        cyc();
        both("seq pc 108", pc_out_d[0], 32'h108, pc_out_d[1], 32'h108);
        both("seq redirect", 32'(redirect_d[0]), 0, 32'(redirect_d[1]), 0);

        // Taken / not-taken branch from 0x200
        pc_sel = PC_ALU; alu_out = 32'h200; cyc();
        both("jump 200", pc_out_d[0], 32'h200, pc_out_d[1], 32'h200);
        pc_sel = PC_B_TARGET; br_flag = 1'b1; imm_b_sext = 32'hFFFF_FFF8; cyc();
        both("branch taken", pc_out_d[0], 32'h1F8, pc_out_d[1], 32'h1F8);
        both("branch redirect", 32'(redirect_d[0]), 1, 32'(redirect_d[1]), 1);
        pc_sel = PC_ALU; alu_out = 32'h200; cyc();
        pc_sel = PC_B_TARGET; br_flag = 1'b0; cyc();
        both("branch not taken", pc_out_d[0], 32'h204, pc_out_d[1], 32'h204);
        both("nt redirect", 32'(redirect_d[0]), 0, 32'(redirect_d[1]), 0);

        // Misaligned jump: traps only under IALIGN=4
        pc_sel = PC_ALU; alu_out = 32'h302; cyc();
        both("misalign pc", pc_out_d[0], 32'h80, pc_out_d[1], 32'h302);
        both("misalign exc", 32'(misalign_exc_d[0]), 1, 32'(misalign_exc_d[1]), 0);
        chk("d4 misalign addr", misalign_addr_d[0], 32'h302);
        pc_sel = PC_PLUS4; cyc();
        both("exc pulse end", 32'(misalign_exc_d[0]), 0, 32'(misalign_exc_d[1]), 0);
        chk("d4 misalign addr held", misalign_addr_d[0], 32'h302);

        // Stall: jump, trap, jump -> trap kept
        stall = 1'b1; pc_sel = PC_ALU; alu_out = 32'h400; cyc();
        pc_sel = PC_ECALL_TARGET; cyc();
        pc_sel = PC_ALU; alu_out = 32'h500; cyc();
        both("held pc", pc_out_d[0], 32'h84, pc_out_d[1], 32'h306);
        both("held pending", 32'(pending_d[0]), 1, 32'(pending_d[1]), 1);
        stall = 1'b0; pc_sel = PC_PLUS4; cyc();
        both("release trap", pc_out_d[0], 32'h80, pc_out_d[1], 32'h80);
        both("release redirect", 32'(redirect_d[0]), 1, 32'(redirect_d[1]), 1);
        both("release pending", 32'(pending_d[0]), 0, 32'(pending_d[1]), 0);

        // Pending jump overridden by MRET at release
        stall = 1'b1; pc_sel = PC_ALU; alu_out = 32'h400; cyc();
        stall = 1'b0; pc_sel = PC_MRET; mepc = 32'h600; cyc();
        both("mret override", pc_out_d[0], 32'h600, pc_out_d[1], 32'h600);
        both("mret pending", 32'(pending_d[0]), 0, 32'(pending_d[1]), 0);

        // Pending trap wins over a jump at release
        stall = 1'b1; pc_sel = PC_ECALL_TARGET; cyc();
        stall = 1'b0; pc_sel = PC_ALU; alu_out = 32'h700; cyc();
        both("trap beats jump", pc_out_d[0], 32'h80, pc_out_d[1], 32'h80);

        // Misaligned target captured during stall pulses at capture
        stall = 1'b1; pc_sel = PC_ALU; alu_out = 32'h302; cyc();
        both("stall misalign exc", 32'(misalign_exc_d[0]), 1, 32'(misalign_exc_d[1]), 0);
        stall = 1'b0; pc_sel = PC_PLUS4; cyc();
        both("stall misalign release", pc_out_d[0], 32'h80, pc_out_d[1], 32'h302);
        both("no exc at release", 32'(misalign_exc_d[0]), 0, 32'(misalign_exc_d[1]), 0);

        // Asynchronous reset while HELD
        stall = 1'b1; pc_sel = PC_ALU; alu_out = 32'h400; cyc();
        both("pre-reset pending", 32'(pending_d[0]), 1, 32'(pending_d[1]), 1);
        #2 x_reset = 1'b0;
        #1;
        both("async pc", pc_out_d[0], 32'h100, pc_out_d[1], 32'h100);
        both("async pending", 32'(pending_d[0]), 0, 32'(pending_d[1]), 0);
        both("async valid", 32'(pc_valid_d[0]), 0, 32'(pc_valid_d[1]), 0);
        both("async maddr", misalign_addr_d[0], 0, misalign_addr_d[1], 0);
        stall = 1'b0; pc_sel = PC_PLUS4; cyc();
        x_reset = 1'b1;
        cyc();
        both("post-reset pc", pc_out_d[0], 32'h100, pc_out_d[1], 32'h100);
        both("post-reset redirect", 32'(redirect_d[0]), 0, 32'(redirect_d[1]), 0);
        cyc();
        both("post-reset seq", pc_out_d[0], 32'h104, pc_out_d[1], 32'h104);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
